uart_rx_buffered: RTL and testbench
===================================

# uart_rx_buffered

Serial receive front-end that feeds the core's memory-mapped UART slave. It synchronises and 16x-oversamples the `rx` pin, deserialises 8N1 frames, and buffers received bytes in a small FIFO. It exposes a data/status register pair on the same `wd`/`address`/`we`/`re`/`rd` slave interface used by the RAM and UART slaves behind the master memory map. It also provides a level interrupt for polling-free firmware.

## Interface
- `CLK_FREQ`, 50_000_000: core clock in Hz.
- `BAUD`, 115200: line rate.
- `DATA_WIDTH`, 32: bus width of `wd`/`rd`/`address`.
- `FIFO_DEPTH`, 8: receive FIFO entries; must be a power of 2, ≥2.

- One clock; reset is synchronous and active-high.
- `clk`  in  1  core clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rx`  in  1  asynchronous serial input; idle high.
- `address`  in  DATA_WIDTH  slave address; only bits [3:2] are decoded.
- `wd`  in  DATA_WIDTH  write data.
- `we`  in  1  write select from the memory map.
- `re`  in  1  read select from the memory map.
- `rd`  out  DATA_WIDTH  read data, combinational.
- `rx_irq`  out  1  high while the FIFO is non-empty.

## Operation
- **Synchroniser:** 2-FF chain on `rx`, both stages reset to 1. All logic uses the second stage (`rx_s`).
- **Oversample tick:** DIV = CLK_FREQ/(BAUD*16), truncated; 27 for the defaults. The tick counter runs 0..DIV-1 and pulses one cycle at DIV-1. It is free-running only outside IDLE, and is cleared to 0 on start-edge detection.
- **FSM** (state reg; sample counter `sc` 0..15; bit counter `bc` 0..7):
  - **IDLE:** a falling edge on `rx_s` → START, with `sc` = 0.
  - **START:** at the tick with `sc` = 7 (mid-bit), sample `rx_s`. If it is 0 → DATA, with `sc` = 0 and `bc` = 0. If it is 1 → IDLE (glitch rejected, nothing logged).
  - **DATA:** at `sc` = 15, shift `rx_s` into the shift register, LSB first. When `bc` = 7 → STOP; otherwise `bc`++.
  - **STOP:** at `sc` = 15, sample `rx_s`. If 1, push the byte. If 0, set sticky `frame_err` and discard the byte. Either way → IDLE in the same cycle, so a new start edge can be detected on the next clock.
- **FIFO:** circular buffer with wr_ptr, rd_ptr and count (0..FIFO_DEPTH).
  - A push while full is dropped and sets sticky `overflow`.
  - If push and pop coincide while full, the pop is applied first. The push succeeds and `overflow` is not set.
  - If push and pop coincide while empty, the pop is ignored and the push succeeds.
  - Pointers wrap modulo FIFO_DEPTH.
- **Register map:**
  - address[3:2] = 0, DATA:
    - `rd` = {24'h0, head byte} when non-empty, else 0.
    - `re` asserted with the FIFO non-empty pops exactly one entry at the clock edge.
  - address[3:2] = 1, STATUS:
    - `rd` = {count zero-extended to bits [15:8], 5'b0, overflow[2], frame_err[1], empty[0]}.
    - Writing with `we` = 1: wd[2] = 1 clears `overflow`; wd[1] = 1 clears `frame_err`.
    - If a set event occurs in the same cycle as a clear, the set wins.
  - Other addresses: `rd` = 0; writes are ignored. Writes to DATA are ignored.
- **Reset mid-frame:** FSM → IDLE, FIFO emptied, flags cleared. A partially received byte is lost.

## Timing
- Reset values:
  - `rd` = 0 for non-STATUS addresses; STATUS reads 32'h0000_0001.
  - `rx_irq` = 0; count = 0; `overflow` = `frame_err` = 0; FSM in IDLE.
- Input latency: 2 clocks through the synchroniser before the FSM sees `rx` edges.
- Byte visibility: the push occurs at the mid-stop sample, about 9.5 bit times after the start edge (≈4124 clocks at defaults, ±DIV). `rx_irq` and count update the cycle after the push.
- `rd` is combinational from the current FIFO head and address. A pop takes effect at the edge that ends the `re` cycle.
- Back-to-back frames with no idle gap are received without loss.

## Structure
- Package `uart_rx_pkg`:
  - state enum {IDLE, START, DATA, STOP};
  - register offsets DATA = 2'd0, STATUS = 2'd1;
  - OVERSAMPLE = 16;
  - status bit positions.
- One sub-module, `rx_fifo` (parameters DEPTH and WIDTH = 8), containing the push/pop/count logic and the full/empty flags. The FSM, tick generator and register decode stay in the top of this block.

## Test plan
- **Single byte:** drive 0xA5 at 115200 8N1, then read DATA → `rd` = 32'h0000_00A5. `rx_irq` rises ≈4124 clocks after the start edge and falls the cycle after the pop; STATUS then = 32'h1.
- **Glitch:** drive a 5-clock low pulse → no push, no error, FSM back in IDLE.
- **Framing error:** send 0x3C with stop bit = 0 → STATUS[1] = 1, count = 0. Write STATUS with wd = 32'h2 → STATUS[1] = 0.
- **Overflow:** send 9 bytes 0x00..0x08 without reading → count = 8, STATUS[2] = 1. Reads return 0x00..0x07 in order; a 9th read returns 0 with no pointer change.
- **Full push+pop:** with FIFO full, pop in the exact cycle of a push → count stays 8, overflow stays 0, the new byte is last out.
- **Reset mid-frame:** assert `rst` during DATA bit 4 → STATUS = 32'h1. The next full frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared FSM states, register offsets and status bit positions for uart_rx_buffered
package uart_rx_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam int OVERSAMPLE = 16;
  localparam int ST_EMPTY = 0;
  localparam int ST_FERR = 1;
  localparam int ST_OVF = 2;
endpackage

// File: rtl/uart_rx_buffered_fifo.sv
// rx_fifo: circular receive buffer; ports clk/rst, push/push_data in, pop in, head/count/full/empty/dropped out
module rx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       dropped
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_pop, do_push;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign do_pop = pop && !empty;
  // a pop frees the slot first, so a push into a full buffer succeeds when both coincide
  assign do_push = push && (!full || do_pop);
  assign dropped = push && !do_push;
  assign head = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= push_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/uart_rx_buffered.sv
// uart_rx_buffered: 8N1 UART receiver with FIFO and DATA/STATUS slave registers; ports clk/rst, rx, address/wd/we/re bus in, rd/rx_irq out
module uart_rx_buffered
  import uart_rx_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD = 115200,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  input  logic [DATA_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] wd,
  input  logic                  we,
  input  logic                  re,
  output logic [DATA_WIDTH-1:0] rd,
  output logic                  rx_irq
);
  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int TW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int CW = $clog2(FIFO_DEPTH+1);
  logic rx_m, rx_s, rx_prev;
  logic [TW-1:0] tcnt;
  logic tick, fall;
  rx_state_t state;
  logic [3:0] sc;
  logic [2:0] bc;
  logic [7:0] shreg;
  logic push, ferr_set;
  logic [7:0] head;
  logic [CW-1:0] count;
  logic full, empty, dropped, pop, st_wr;
  logic overflow, frame_err;
  logic [1:0] sel;
  logic [15:0] status;
  logic unused_bits;
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_prev <= rx_s;
    end
  end
  assign fall = rx_prev && !rx_s;
  // held at zero in IDLE so the first tick lands DIV clocks after the start edge
  assign tick = state != IDLE && tcnt == TW'(DIV-1);
  always_ff @(posedge clk) begin
    if (rst || state == IDLE) tcnt <= '0;
    else tcnt <= tick ? '0 : tcnt + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sc <= '0;
      bc <= '0;
      shreg <= '0;
      push <= 1'b0;
      ferr_set <= 1'b0;
    end else begin
      push <= 1'b0;
      ferr_set <= 1'b0;
      case (state)
        IDLE: if (fall) begin
          state <= START;
          sc <= '0;
        end
        START: if (tick) begin
          if (sc == 4'(OVERSAMPLE/2-1)) begin
            state <= rx_s ? IDLE : DATA;
            sc <= '0;
            bc <= '0;
          end else sc <= sc + 1'b1;
        end
        DATA: if (tick) begin
          sc <= sc + 1'b1;
          if (sc == 4'(OVERSAMPLE-1)) begin
            shreg <= {rx_s, shreg[7:1]};
            if (bc == 3'd7) state <= STOP;
            else bc <= bc + 1'b1;
          end
        end
        STOP: if (tick) begin
          sc <= sc + 1'b1;
          if (sc == 4'(OVERSAMPLE-1)) begin
            state <= IDLE;
            push <= rx_s;
            ferr_set <= !rx_s;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign sel = address[3:2];
  assign pop = re && sel == REG_DATA;
  assign st_wr = we && sel == REG_STATUS;
  rx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .push_data(shreg),
    .pop(pop),
    .head(head),
    .count(count),
    .full(full),
    .empty(empty),
    .dropped(dropped)
  );
  // set events take priority over a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overflow <= dropped || (overflow && !(st_wr && wd[ST_OVF]));
      frame_err <= ferr_set || (frame_err && !(st_wr && wd[ST_FERR]));
    end
  end
  assign status = {8'(count), 5'b0, overflow, frame_err, empty};
  assign rd = sel == REG_DATA ? DATA_WIDTH'(empty ? 8'h0 : head) :
              sel == REG_STATUS ? DATA_WIDTH'(status) : '0;
  assign rx_irq = !empty;
  assign unused_bits = ^{address[DATA_WIDTH-1:4], address[1:0], wd[DATA_WIDTH-1:3], wd[0], full};
endmodule

// File: tb/tb_uart_rx_buffered.sv
// tb_uart_rx_buffered: randomized self-checking bench with a queue-based receive model
module tb_uart_rx_buffered;
  localparam int CLK_FREQ = 10_000_000;
  localparam int BAUD = 115200;
  localparam int DIV = CLK_FREQ / (BAUD * 16);
  localparam int BIT = DIV * 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx = 1'b1;
  logic [31:0] address = '0;
  logic [31:0] wd = '0;
  logic we = 1'b0;
  logic re = 1'b0;
  logic [31:0] rd;
  logic rx_irq;
  int checks = 0;
  int failures = 0;
  logic [7:0] q[$];
  logic m_ovf = 1'b0;
  logic m_ferr = 1'b0;
  logic [31:0] v;
  int n;
  logic found;
  logic [7:0] b;

  uart_rx_buffered #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_WIDTH(32), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .rx(rx), .address(address), .wd(wd),
    .we(we), .re(re), .rd(rd), .rx_irq(rx_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    return {16'h0, 8'(q.size()), 5'b0, m_ovf, m_ferr, q.size() == 0};
  endfunction

  function automatic void model_frame(input logic [7:0] d, input logic stop);
    if (!stop) m_ferr = 1'b1;
    else if (q.size() == 8) m_ovf = 1'b1;
    else q.push_back(d);
  endfunction

  task automatic send_byte(input logic [7:0] d, input logic stop);
    @(negedge clk); rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BIT) @(negedge clk);
    end
    rx = stop;
    repeat (BIT) @(negedge clk);
    rx = 1'b1;
    if (!stop) repeat (BIT) @(negedge clk);
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] r);
    @(negedge clk); address = a; re = 1'b1;
    #1 r = rd;
    @(posedge clk); #1 re = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk); address = a; wd = d; we = 1'b1;
    @(posedge clk); #1 we = 1'b0;
  endtask

  task automatic read_data_model(input string tag);
    logic [31:0] e;
    e = q.size() ? {24'h0, q[0]} : 32'h0;
    if (q.size()) void'(q.pop_front());
    bus_read(32'h0, v);
    check(tag, v, e);
  endtask

  task automatic check_status(input string tag);
    bus_read(32'h4, v);
    check(tag, v, exp_status());
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_irq", {31'h0, rx_irq}, 32'h0);
    check_status("rst_status");
    bus_read(32'h0, v); check("rst_data", v, 32'h0);
    bus_read(32'hC, v); check("rst_addr3", v, 32'h0);
    bus_read(32'hFFFF_FFF4, v); check("rst_status_hi", v, 32'h1);

    // single byte with interrupt latency
    n = 0;
    fork
      send_byte(8'hA5, 1'b1);
      while (n < 2 * 10 * BIT && !rx_irq) begin
        @(negedge clk); n++;
      end
    join
    check("irq_lat", {31'h0, (n >= (BIT * 19) / 2 - DIV) && (n <= (BIT * 19) / 2 + DIV + 8)}, 32'h1);
    model_frame(8'hA5, 1'b1);
    check("a5_status", {31'h0, rx_irq}, 32'h1);
    read_data_model("a5_data");
    check("a5_irq_fall", {31'h0, rx_irq}, 32'h0);
    check_status("a5_status_after");

    // randomized bursts of back-to-back frames
    for (int r = 0; r < 5; r++) begin
      int nb;
      nb = $urandom_range(1, 3);
      for (int k = 0; k < nb; k++) begin
        logic s;
        b = 8'($urandom);
        s = $urandom_range(0, 3) != 0;
        send_byte(b, s);
        model_frame(b, s);
      end
      check_status("rand_status");
      if ($urandom_range(0, 1)) begin
        bus_write(32'h4, 32'h2);
        m_ferr = 1'b0;
      end
      for (int k = 0; k < nb + 1; k++) read_data_model("rand_data");
      bus_write(32'h4, 32'h6);
      m_ferr = 1'b0;
      m_ovf = 1'b0;
    end

    // glitch shorter than half a bit
    @(negedge clk); rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (12 * BIT) @(negedge clk);
    check_status("glitch_status");
    send_byte(8'h69, 1'b1); model_frame(8'h69, 1'b1);
    read_data_model("post_glitch");

    // framing error, ignored writes, flag clear
    send_byte(8'h3C, 1'b0); model_frame(8'h3C, 1'b0);
    check_status("ferr_set");
    bus_write(32'h0, 32'hFFFF_FFFF);
    bus_write(32'h8, 32'hFFFF_FFFF);
    check_status("ferr_ignored_wr");
    bus_write(32'h4, 32'h2); m_ferr = 1'b0;
    check_status("ferr_clear");

    // overflow
    for (int k = 0; k < 9; k++) begin
      send_byte(8'(k), 1'b1);
      model_frame(8'(k), 1'b1);
    end
    check_status("ovf_status");
    for (int k = 0; k < 9; k++) read_data_model("ovf_data");
    check_status("ovf_drained");
    bus_write(32'h4, 32'h4); m_ovf = 1'b0;
    check_status("ovf_clear");

    // pop in the exact cycle of a push into a full FIFO
    for (int k = 0; k < 8; k++) begin
      b = 8'($urandom);
      send_byte(b, 1'b1);
      model_frame(b, 1'b1);
    end
    b = 8'($urandom);
    found = 1'b0;
    fork
      send_byte(b, 1'b1);
      begin
        for (int i = 0; i < 2 * 10 * BIT; i++) begin
          @(negedge clk);
          if (dut.push) begin
            found = 1'b1;
            break;
          end
        end
        if (found) begin
          address = 32'h0; re = 1'b1;
          #1 v = rd;
          @(posedge clk); #1 re = 1'b0;
        end
      end
    join
    check("pp_seen", {31'h0, found}, 32'h1);
    check("pp_pop", v, {24'h0, q[0]});
    void'(q.pop_front());
    model_frame(b, 1'b1);
    check_status("pp_status");
    for (int k = 0; k < 8; k++) read_data_model("pp_data");

    // reset during data bit 4
    send_byte(8'h11, 1'b1); model_frame(8'h11, 1'b1);
    send_byte(8'h22, 1'b0); model_frame(8'h22, 1'b0);
    b = 8'hF0 | 8'($urandom_range(0, 15));
    fork
      send_byte(b, 1'b1);
      begin
        repeat (BIT * 5 + BIT / 2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
      end
    join
    q.delete(); m_ovf = 1'b0; m_ferr = 1'b0;
    repeat (BIT) @(negedge clk);
    check("mid_rst_status", exp_status(), 32'h1);
    check_status("mid_rst_dut");
    send_byte(8'h5A, 1'b1); model_frame(8'h5A, 1'b1);
    read_data_model("post_rst_5a");
    check_status("final_status");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
